// File: rtl/decoder_pkg.sv
`default_nettype none
// ==========================================================================
// decoder_pkg: shared defaults and state encoding for the decoder slice.
// Revision: 1.0
// ==========================================================================
package decoder_pkg;

  localparam int N_DEF       = 3;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } seq_state_e;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/dwell_counter.sv
`default_nettype none
// ==========================================================================
// dwell_counter: loadable down-counter that saturates at zero.
// Revision: 1.0
// ==========================================================================
module dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_d;
  logic [DWELL_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule : dwell_counter
`default_nettype wire

// File: rtl/decoder_index_sequencer.sv
`default_nettype none
// ==========================================================================
// decoder_index_sequencer: steps a registered N-bit decoder select index
// through 0..last_idx (up or down) with a programmable per-index dwell.
// Revision: 1.0
// ==========================================================================
module decoder_index_sequencer
  import decoder_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic               dir_down,
  input  logic [N-1:0]       last_idx,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N-1:0]       idx,
  output logic               idx_valid,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  seq_state_e         state_d,     state_q;
  logic [N-1:0]       idx_d,       idx_q;
  logic               idx_valid_d, idx_valid_q;
  logic               busy_d,      busy_q;
  logic               done_d,      done_q;
  logic               wrap_d,      wrap_q;
  logic               mode_cont_d, mode_cont_q;
  logic               dir_down_d,  dir_down_q;
  logic [N-1:0]       last_idx_d,  last_idx_q;
  logic [DWELL_W-1:0] dwell_d,     dwell_q;

  logic               cnt_clr;
  logic               cnt_load;
  logic               cnt_en;
  logic [DWELL_W-1:0] cnt_load_val;
  logic               cnt_zero;

  logic [N-1:0]       start_val;
  logic [N-1:0]       end_val;

  dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  // Scan endpoints come from the latched config, never the live inputs.
  assign start_val = dir_down_q ? last_idx_q : '0;
  assign end_val   = dir_down_q ? '0 : last_idx_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    idx_valid_d  = idx_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    wrap_d       = 1'b0;
    mode_cont_d  = mode_cont_q;
    dir_down_d   = dir_down_q;
    last_idx_d   = last_idx_q;
    dwell_d      = dwell_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = dwell_q;

    unique case (state_q)
      IDLE: begin
        idx_d       = '0;
        idx_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (start && !stop) begin
          state_d      = ACTIVE;
          mode_cont_d  = mode_cont;
          dir_down_d   = dir_down;
          last_idx_d   = last_idx;
          dwell_d      = dwell;
          idx_d        = dir_down ? last_idx : '0;
          idx_valid_d  = 1'b1;
          busy_d       = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = dwell;
        end
      end

      ACTIVE: begin
        if (stop) begin
          state_d     = IDLE;
          idx_d       = '0;
          idx_valid_d = 1'b0;
          busy_d      = 1'b0;
          cnt_clr     = 1'b1;
        end else if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else if (idx_q != end_val) begin
          idx_d    = dir_down_q ? (idx_q - N'(1)) : (idx_q + N'(1));
          cnt_load = 1'b1;
        end else if (mode_cont_q) begin
          idx_d    = start_val;
          cnt_load = 1'b1;
          wrap_d   = 1'b1;
        end else begin
          state_d     = IDLE;
          idx_d       = '0;
          idx_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          cnt_clr     = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      mode_cont_q <= 1'b0;
      dir_down_q  <= 1'b0;
      last_idx_q  <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      mode_cont_q <= mode_cont_d;
      dir_down_q  <= dir_down_d;
      last_idx_q  <= last_idx_d;
      dwell_q     <= dwell_d;
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrap      = wrap_q;

endmodule : decoder_index_sequencer
`default_nettype wire

// File: tb/tb_decoder_index_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_decoder_index_sequencer: scoreboard bench with a per-cycle scan model.
// Revision: 1.0
// ==========================================================================
module tb_decoder_index_sequencer;

  localparam int N       = 3;
  localparam int DWELL_W = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic               stop;
  logic               mode_cont;
  logic               dir_down;
  logic [N-1:0]       last_idx;
  logic [DWELL_W-1:0] dwell;
  logic [N-1:0]       idx;
  logic               idx_valid;
  logic               busy;
  logic               done;
  logic               wrap;

  typedef struct {
    int idx;
    bit valid;
    bit busy;
    bit done;
    bit wrap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp;
  int   n_err;
  bit   mon_off;

  decoder_index_sequencer #(
    .N       (N),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode_cont (mode_cont),
    .dir_down  (dir_down),
    .last_idx  (last_idx),
    .dwell     (dwell),
    .idx       (idx),
    .idx_valid (idx_valid),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: any live output consumes one scoreboard entry; quiet cycles
  // must look fully idle.
  always @(negedge clk) begin
    if (!rst && !mon_off) begin
      if (idx_valid || busy || done || wrap) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output idx=%0d valid=%0d busy=%0d done=%0d wrap=%0d expected idle",
                   idx, idx_valid, busy, done, wrap);
        end else begin
          mon_e = exp_q.pop_front();
          if (int'(idx) != mon_e.idx || idx_valid != mon_e.valid || busy != mon_e.busy ||
              done != mon_e.done || wrap != mon_e.wrap) begin
            n_err++;
            $display("FAIL scan_cycle got idx=%0d valid=%0d busy=%0d done=%0d wrap=%0d expected idx=%0d valid=%0d busy=%0d done=%0d wrap=%0d",
                     idx, idx_valid, busy, done, wrap,
                     mon_e.idx, mon_e.valid, mon_e.busy, mon_e.done, mon_e.wrap);
          end
        end
      end else begin
        n_cmp++;
        if (idx != '0) begin
          n_err++;
          $display("FAIL idle_idx got idx=%0d expected 0", idx);
        end
      end
    end
  end

  // Reference: cycle j of a scan shows index position (j/(d+1)) mod (L+1);
  // a wrap flag marks every full period after the first.
  task automatic run_scan(input int l, input int d, input bit cont, input bit down, input int s);
    int  p;
    int  n;
    int  pos;
    int  lim;
    bit  stopped;
    exp_t e;
    p       = (l + 1) * (d + 1);
    stopped = cont || (s != 0 && s <= p);
    n       = cont ? s : (stopped ? s : p);
    for (int j = 0; j < n; j++) begin
      pos     = (j / (d + 1)) % (l + 1);
      e.idx   = down ? (l - pos) : pos;
      e.valid = 1'b1;
      e.busy  = 1'b1;
      e.done  = 1'b0;
      e.wrap  = (j > 0) && (j % p == 0);
      exp_q.push_back(e);
    end
    if (!stopped) begin
      e.idx = 0; e.valid = 1'b0; e.busy = 1'b0; e.done = 1'b1; e.wrap = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start     = 1'b1;
    stop      = 1'b0;
    mode_cont = cont;
    dir_down  = down;
    last_idx  = N'(l);
    dwell     = DWELL_W'(d);
    @(negedge clk);
    lim = cont ? s : n + 2;
    for (int k = 1; k <= lim; k++) begin
      stop      = (k == s);
      start     = (k <= n) && ($urandom_range(0, 7) == 0);
      mode_cont = 1'($urandom);
      dir_down  = 1'($urandom);
      last_idx  = N'($urandom);
      dwell     = DWELL_W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scan_drain got %0d leftover entries expected 0 (L=%0d d=%0d cont=%0d down=%0d s=%0d)",
               exp_q.size(), l, d, cont, down, s);
      exp_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_cmp++;
    if (idx != '0 || idx_valid || busy || done || wrap) begin
      n_err++;
      $display("FAIL %s got idx=%0d valid=%0d busy=%0d done=%0d wrap=%0d expected all 0",
               name, idx, idx_valid, busy, done, wrap);
    end
  endtask

  task automatic reset_mid_scan();
    int  guard;
    mon_off = 1'b1;
    @(negedge clk);
    start = 1'b1; mode_cont = 1'b0; dir_down = 1'b0; last_idx = 3'd5; dwell = 8'd2;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (idx != 3'd2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (idx != 3'd2) begin
      n_err++;
      $display("FAIL reach_idx2 got idx=%0d expected 2", idx);
    end
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_reset");
    @(negedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    mon_off = 1'b0;
  endtask

  initial begin
    int l;
    int d;
    int p;
    bit cont;
    int s;
    n_cmp = 0; n_err = 0; mon_off = 1'b0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    mode_cont = 1'b0; dir_down = 1'b0; last_idx = '0; dwell = '0;
    #1 check_outputs_zero("reset_state");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_scan(2, 1, 1'b0, 1'b0, 0);      // one-shot up, done at cycle 7
    run_scan(7, 0, 1'b1, 1'b1, 9);      // continuous down, wrap on second 7
    run_scan(2, 1, 1'b0, 1'b0, 4);      // stop at cycle 4
    run_scan(0, 3, 1'b0, 1'b0, 0);      // single index, dwell 3
    run_scan(0, 0, 1'b1, 1'b0, 5);      // wrap every cycle
    run_scan(7, 255, 1'b0, 1'b1, 0);    // max dwell and index
    run_scan(3, 2, 1'b0, 1'b0, 12);     // stop on the done cycle

    @(negedge clk);
    start = 1'b1; stop = 1'b1; last_idx = 3'd4; dwell = 8'd1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);

    reset_mid_scan();
    run_scan(5, 2, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      l    = $urandom_range(0, 7);
      d    = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 3);
      cont = 1'($urandom);
      p    = (l + 1) * (d + 1);
      if (cont) s = $urandom_range(1, 2 * p + 2);
      else      s = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, p + 1);
      run_scan(l, d, cont, 1'($urandom), s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_decoder_index_sequencer
`default_nettype wire
